// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment search engine: matrix size,
// cost/index widths, checksum width and the cost-table load states.
package jam_pkg;

   localparam int N  = 8;        // workers = jobs, power of 2
   localparam int CW = 7;        // cost width
   localparam int IW = 3;        // index width, log2(N)
   localparam int SW = 13;       // checksum width, >= CW + 2*IW
   localparam int NN = N * N;    // entries in the matrix
   localparam int AW = 2 * IW;   // flat (worker, job) address width

   typedef logic [CW-1:0] cost_t;
   typedef logic [IW-1:0] idx_t;
   typedef logic [AW-1:0] addr_t;
   typedef logic [SW-1:0] sum_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   localparam addr_t LAST_ADDR = addr_t'(NN - 1);

   // Row-major flat address: worker in the upper bits, job in the lower.
   function automatic addr_t cell_addr(input idx_t w, input idx_t j);
      return {w, j};
   endfunction

endpackage

// File: rtl/jam_cost_loader.sv
// Load sequencer for the cost table: FSM, load index, framing check and
// optional running checksum (enabled by JAM_COST_CKSUM_EN).
//
//  state | meaning
//  ------+------------------------------------------------------------
//  EMPTY | no table; one idle cycle before loading restarts
//  LOAD  | accepting beats, in_ready=1, idx counts written entries
//  READY | full matrix held, tbl_ready=1, stream ignored
module jam_cost_loader
   import jam_pkg::*;
(
   input  logic          CLK,
   input  logic          RST,
   input  logic          in_valid,
   input  logic [CW-1:0] in_data,
   input  logic          in_last,
   input  logic          clear,
   output logic          in_ready,
   output logic          tbl_ready,
   output logic          load_err,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [CW-1:0] wr_data,
   output logic [SW-1:0] cksum
);

   state_t state;
   addr_t  idx;
   logic   accept;
   logic   at_last;
   logic   frame_bad;

   assign accept    = in_valid && (state == LOAD);
   assign at_last   = (idx == LAST_ADDR);
   // in_last must coincide exactly with the final index, in both directions.
   assign frame_bad = accept && (in_last != at_last);

   assign in_ready  = (state == LOAD);
   assign tbl_ready = (state == READY);

   // clear wins over any beat offered in the same cycle.
   assign wr_en   = accept && !clear;
   assign wr_addr = idx;
   assign wr_data = in_data;

   // State sequencing, load index and framing-error pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= EMPTY;
         idx      <= '0;
         load_err <= 1'b0;
      end else begin
         load_err <= 1'b0;
         if (clear) begin
            state <= LOAD;
            idx   <= '0;
         end else begin
            unique case (state)
               EMPTY: state <= LOAD;
               LOAD: begin
                  if (accept) begin
                     if (frame_bad) begin
                        load_err <= 1'b1;
                        idx      <= '0;
                        state    <= EMPTY;
                     end else begin
                        idx <= addr_t'(idx + 1'b1);
                        if (at_last) state <= READY;
                     end
                  end
               end
               READY:   state <= READY;
               default: state <= EMPTY;
            endcase
         end
      end
   end

`ifdef JAM_COST_CKSUM_EN
   sum_t acc;

   // Running sum of written entries; width chosen so it cannot overflow.
   always_ff @(posedge CLK) begin
      if (RST || clear || frame_bad) begin
         acc <= '0;
      end else if (wr_en) begin
         acc <= acc + sum_t'(in_data);
      end
   end

   assign cksum = acc;
`else
   assign cksum = '0;
`endif

endmodule

// File: rtl/jam_cost_table.sv
// NxN worker/job cost store. Loaded row-major over a valid/ready stream,
// read combinationally so the search engine sees Cost in the same cycle it
// drives W/J. Optional checksum output enabled by JAM_COST_CKSUM_EN.
module jam_cost_table
   import jam_pkg::*;
(
   input  logic          CLK,
   input  logic          RST,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_data,
   input  logic          in_last,
   input  logic          clear,
   input  logic [IW-1:0] W,
   input  logic [IW-1:0] J,
   output logic [CW-1:0] Cost,
   output logic          tbl_ready,
   output logic          load_err,
   output logic [SW-1:0] cksum
);

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [CW-1:0] wr_data;

   // Storage is deliberately not reset; tbl_ready gates every read instead.
   cost_t mem [NN];

   jam_cost_loader u_loader (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .clear     (clear),
      .in_ready  (in_ready),
      .tbl_ready (tbl_ready),
      .load_err  (load_err),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cksum     (cksum)
   );

   // Matrix write port driven by the loader.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign Cost = tbl_ready ? mem[cell_addr(W, J)] : '0;

endmodule
